// File: rtl/cla_word_sequencer_pkg.sv
// cla_word_sequencer_pkg: shared slice width and sequencer state encoding
package cla_word_sequencer_pkg;
  localparam int NIBBLE = 4;
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/cla_nibble_slice.sv
// cla_nibble_slice: combinational 4-bit carry-lookahead adder slice
module cla_nibble_slice
  import cla_word_sequencer_pkg::*;
(
  input  logic [NIBBLE-1:0] a,
  input  logic [NIBBLE-1:0] b,
  input  logic              cin,
  output logic [NIBBLE-1:0] s,
  output logic [NIBBLE-1:0] carries
);
  logic [NIBBLE-1:0] p, g;
  assign p = a ^ b;
  assign g = a & b;
  // c[i+1] = g[i] | p[i]&c[i], fully expanded so no carry depends on another
  assign carries[0] = g[0] | (p[0] & cin);
  assign carries[1] = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
  assign carries[2] = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & cin);
  assign carries[3] = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]) | (&p[3:0] & cin);
  assign s = p ^ {carries[2:0], cin};
endmodule

// File: rtl/cla_word_sequencer.sv
// cla_word_sequencer: word add/subtract computed one CLA nibble per cycle, LSB first
module cla_word_sequencer
  import cla_word_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             op_sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);
  localparam int N  = WIDTH / NIBBLE;
  localparam int CW = $clog2(N);
  state_t            state;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  a_r, b_r;
  logic              op_r, carry;
  logic [NIBBLE-1:0] a_n, b_n, s_n, c_n;
  assign a_n  = a_r[NIBBLE*cnt +: NIBBLE];
  assign b_n  = op_r ? ~b_r[NIBBLE*cnt +: NIBBLE] : b_r[NIBBLE*cnt +: NIBBLE];
  assign busy = state != IDLE;
  cla_nibble_slice u_slice (
    .a      (a_n),
    .b      (b_n),
    .cin    (carry),
    .s      (s_n),
    .carries(c_n)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 1'b0;
      carry    <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          a_r   <= a;
          b_r   <= b;
          op_r  <= op_sub;
          carry <= op_sub | c_in;
          cnt   <= '0;
          state <= ADD;
        end
        ADD: begin
          sum[NIBBLE*cnt +: NIBBLE] <= s_n;
          carry <= c_n[NIBBLE-1];
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state    <= DONE;
            done     <= 1'b1;
            c_out    <= c_n[NIBBLE-1];
            overflow <= c_n[NIBBLE-2] ^ c_n[NIBBLE-1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cla_word_sequencer.sv
// tb_cla_word_sequencer: directed and random checks of the serial CLA sequencer at WIDTH 32 and 8
module tb_cla_word_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, start8 = 1'b0, c_in = 1'b0, op_sub = 1'b0;
  logic [31:0] a = '0, b = '0, sum;
  logic [7:0]  sum8;
  logic        busy, done, c_out, overflow, busy8, done8, c_out8, overflow8;
  int          checks = 0, failures = 0;
  always #5 clk = ~clk;
  cla_word_sequencer #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in), .op_sub(op_sub),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out), .overflow(overflow)
  );
  cla_word_sequencer #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start8), .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .op_sub(op_sub),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(c_out8), .overflow(overflow8)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  // Reference: plain w-bit arithmetic on A + (B or ~B) + carry-in
  function automatic void model(input int w, input logic [31:0] ta, input logic [31:0] tb,
                                input logic tc, input logic to, output logic [31:0] es,
                                output logic eco, output logic eov);
    longint unsigned mask, x, y, s;
    mask = (64'd1 << w) - 64'd1;
    x    = 64'(ta) & mask;
    y    = (to ? 64'(~tb) : 64'(tb)) & mask;
    s    = x + y + (to ? 64'd1 : 64'(tc));
    es   = 32'(s & mask);
    eco  = s[w];
    eov  = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
  endfunction
  task automatic run(input int w, input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                     input logic to, input int poke, input string tag);
    logic [31:0] es;
    logic        eco, eov;
    int          lat;
    model(w, ta, tb, tc, to, es, eco, eov);
    a = ta; b = tb; c_in = tc; op_sub = to;
    if (w == 32) start = 1'b1; else start8 = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      start = 1'b0; start8 = 1'b0;
      if (lat == poke) begin
        a = 32'h9; b = 32'h9;
        if (w == 32) start = 1'b1; else start8 = 1'b1;
      end else begin
        a = $urandom; b = $urandom; c_in = 1'($urandom); op_sub = 1'($urandom);
      end
      if (lat == 2) chk({tag, "_busy_mid"}, (w == 32) ? busy : busy8, 1);
      if ((w == 32) ? done : done8) break;
    end
    chk({tag, "_latency"}, lat, w / 4 + 1);
    chk({tag, "_sum"}, (w == 32) ? sum : {24'b0, sum8}, es);
    chk({tag, "_c_out"}, (w == 32) ? c_out : c_out8, eco);
    chk({tag, "_overflow"}, (w == 32) ? overflow : overflow8, eov);
    @(negedge clk);
    start = 1'b0; start8 = 1'b0;
    chk({tag, "_done_once"}, (w == 32) ? done : done8, 0);
    chk({tag, "_idle_after"}, (w == 32) ? busy : busy8, 0);
  endtask
  initial begin
    int seen, lat;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_c_out", c_out, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_sum8", sum8, 0);
    reset = 1'b0;
    @(negedge clk);
    run(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 0, "wrap_add");
    run(32, 32'h5, 32'h7, 1'b1, 1'b1, 0, "sub_borrow");
    run(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 0, "pos_ovf");
    run(32, 32'h1, 32'h2, 1'b0, 1'b0, 3, "ignore_busy_start");
    run(32, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 9, "ignore_done_start");
    run(32, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b1, 0, "sub_equal");
    run(32, 32'h8000_0000, 32'h1, 1'b0, 1'b1, 0, "neg_sub_ovf");
    // Abort in the fourth ADD cycle
    a = 32'hAAAA_AAAA; b = 32'h5555_5555; c_in = 1'b1; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_sum", sum, 0);
    chk("abort_done", done, 0);
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);
    run(32, 32'h10, 32'h20, 1'b0, 1'b0, 0, "post_abort");
    reset = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("reset_beats_start", busy, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("reset_beats_start_idle", busy, 0);
    // Start held high: exactly one IDLE cycle between done and the next acceptance
    a = 32'h3; b = 32'h4; c_in = 1'b0; op_sub = 1'b0; start = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("b2b_latency", lat, 9);
    @(negedge clk);
    chk("b2b_gap_idle", busy, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_reaccept", busy, 1);
    lat = 1;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    chk("b2b_latency2", lat, 9);
    chk("b2b_sum2", sum, 32'h7);
    @(negedge clk);
    for (int i = 0; i < 20; i++)
      run(32, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, "rand32");
    run(8, 32'h80, 32'h80, 1'b0, 1'b0, 0, "w8_ovf");
    run(8, 32'h0F, 32'hF0, 1'b1, 1'b0, 0, "w8_carry_chain");
    for (int i = 0; i < 10; i++)
      run(8, $urandom, $urandom, 1'($urandom), 1'($urandom), 0, "rand8");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
